// File: rtl/atwd_readout.sv
// atwd_readout: streams a header plus a window of ATWD buffer samples over valid/ready
module atwd_readout #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   n_words,
    input  logic [1:0]        chan,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE = 1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [1:0]        chan_q, chan_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   iss_q, iss_d;
    logic [ADDR_W:0]   sent_q, sent_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] b0_q, b0_d, b1_q, b1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W:0]   n_clamp;
    logic              pop, last, issue;

    assign n_clamp   = n_words > DEPTH ? DEPTH : n_words;
    assign last      = sent_q == n_q - ONE;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign rdaddress = raddr_q;
    assign out_valid = state_q == S_HDR || (state_q == S_DATA && (cnt_q != 2'd0 || pend_q));
    assign out_last  = state_q == S_HDR ? n_q == '0 : state_q == S_DATA && out_valid && last;
    assign out_data  = state_q == S_HDR ? DATA_W'({2'b10, chan_q, 2'b00, n_q}) :
                       state_q != S_DATA ? '0 :
                       cnt_q != 2'd0 ? b0_q : pend_q ? q : '0;
    assign pop       = state_q == S_DATA && out_valid && out_ready;

    // Skid buffer bookkeeping, read issue and sequencing; a read is issued only if at most one
    // entry will be occupied after this cycle, so the returning word always finds a free slot
    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        chan_d  = chan_q;
        n_d     = n_q;
        iss_d   = iss_q;
        sent_d  = sent_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        cnt_d   = cnt_q;
        if (pop && cnt_q != 2'd0) begin
            b0_d  = b1_q;
            cnt_d = cnt_q - 2'd1;
        end
        if (pend_q && !(pop && cnt_q == 2'd0)) begin
            if (cnt_d == 2'd0) b0_d = q;
            else b1_d = q;
            cnt_d = cnt_d + 2'd1;
        end
        issue  = (state_q == S_HDR || state_q == S_DATA) && iss_q < n_q && cnt_d <= 2'd1;
        pend_d = issue;
        if (issue) begin
            iss_d = iss_q + ONE;
            if (iss_q + ONE < n_q) raddr_d = raddr_q + ADDR_W'(1);
        end
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_HDR;
                n_d     = n_clamp;
                chan_d  = chan;
                iss_d   = '0;
                sent_d  = '0;
                if (n_clamp != '0) raddr_d = start_addr;
            end
            S_HDR:  if (out_ready) state_d = n_q == '0 ? S_DONE : S_DATA;
            S_DATA: if (pop) begin
                sent_d = sent_q + ONE;
                if (last) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            raddr_d = raddr_q;
            pend_d  = 1'b0;
            cnt_d   = 2'd0;
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            raddr_q <= '0;
            chan_q  <= '0;
            n_q     <= '0;
            iss_q   <= '0;
            sent_q  <= '0;
            pend_q  <= 1'b0;
            b0_q    <= '0;
            b1_q    <= '0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            chan_q  <= chan_d;
            n_q     <= n_d;
            iss_q   <= iss_d;
            sent_q  <= sent_d;
            pend_q  <= pend_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_atwd_readout.sv
// tb_atwd_readout: scoreboard bench for the ATWD readout sequencer
module tb_atwd_readout;
    logic        CLK = 0, RST_N = 0;
    logic        start = 0, abort = 0, out_ready = 1;
    logic [8:0]  start_addr = 0;
    logic [9:0]  n_words = 0;
    logic [1:0]  chan = 0;
    logic        busy, done, out_valid, out_last;
    logic [8:0]  rdaddress;
    logic [15:0] q = 0, out_data;
    logic [15:0] mem [512];
    logic [16:0] sb [$];
    int total = 0, bad = 0, cyc = 0, done_cnt = 0, done_exp = 0, mode = 0;
    logic        stall_q = 0;
    logic [15:0] prev_data = 0;

    atwd_readout dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .start_addr(start_addr), .n_words(n_words),
        .chan(chan), .abort(abort), .busy(busy), .done(done), .rdaddress(rdaddress), .q(q),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) q <= mem[rdaddress];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        #1;
        out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Monitor: pops expected words on every handshake and checks stall stability
    always @(negedge CLK) begin
        if (RST_N) begin
            logic [16:0] e;
            if (done) done_cnt++;
            if (stall_q) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_word", out_data, 17'h1ffff);
                else begin
                    e = sb.pop_front();
                    chk("data", out_data, e[15:0]);
                    chk("last", out_last, e[16]);
                end
            end
            stall_q   = out_valid && !out_ready && !abort;
            prev_data = out_data;
        end
    end

    task automatic push_words(input logic [8:0] sa, input int n, input int total_n);
        for (int i = 0; i < n; i++) begin
            logic [8:0] a;
            a = sa + 9'(i);
            sb.push_back({i == total_n - 1, 16'h1000 + {7'd0, a}});
        end
    endtask

    task automatic issue_start(input logic [8:0] sa, input logic [9:0] nw, input logic [1:0] ch,
                               output int t0);
        @(posedge CLK);
        #1;
        start = 1; start_addr = sa; n_words = nw; chan = ch;
        t0 = cyc;
        @(posedge CLK);
        #1;
        start = 0; start_addr = ~sa; n_words = 10'd7; chan = ~ch;
    endtask

    task automatic stream(input logic [8:0] sa, input logic [9:0] nw, input logic [1:0] ch,
                          input logic [15:0] hdr, input int n, input int exp_lat, input bit dup);
        int t0, k;
        sb.push_back({n == 0, hdr});
        push_words(sa, n, n);
        done_exp++;
        issue_start(sa, nw, ch, t0);
        if (dup) begin
            @(posedge CLK);
            @(posedge CLK);
            #1;
            start = 1; start_addr = 9'h100; n_words = 10'd2; chan = 2'd3;
            @(posedge CLK);
            #1;
            start = 0;
        end
        k = 0;
        @(negedge CLK);
        while (!done && k < 5000) begin
            @(negedge CLK);
            k++;
        end
        if (!done) chk("done_timeout", 0, 1);
        else if (exp_lat >= 0) chk("done_latency", cyc - t0, exp_lat);
    endtask

    initial begin
        int t0;
        for (int a = 0; a < 512; a++) mem[a] = 16'h1000 + 16'(a);
        repeat (3) @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_rdaddr", rdaddress, 0);
        @(posedge CLK);
        #1;
        RST_N = 1;

        stream(9'h010, 10'd4, 2'd2, 16'hA004, 4, 6, 0);
        stream(9'h1FE, 10'd4, 2'd0, 16'h8004, 4, 6, 0);
        chk("wrap_rdaddr", rdaddress, 9'h001);
        stream(9'h0C0, 10'd0, 2'd0, 16'h8000, 0, 2, 0);
        chk("n0_rdaddr", rdaddress, 9'h001);
        stream(9'h123, 10'd600, 2'd1, 16'h9200, 512, 514, 0);
        mode = 1;
        stream(9'h0A0, 10'd512, 2'd3, 16'hB200, 512, -1, 0);
        mode = 0;
        stream(9'h040, 10'd8, 2'd2, 16'hA008, 8, 10, 1);

        sb.push_back({1'b0, 16'h9010});
        push_words(9'h050, 4, 16);
        issue_start(9'h050, 10'd16, 2'd1, t0);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        mode = 2;
        @(posedge CLK);
        #1;
        abort = 1;
        @(posedge CLK);
        #1;
        abort = 0;
        @(negedge CLK);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_last", out_last, 0);
        chk("abort_no_done", done_cnt, done_exp);
        chk("abort_sb_empty", sb.size(), 0);
        mode = 0;
        stream(9'h070, 10'd3, 2'd0, 16'h8003, 3, 5, 0);

        repeat (3) @(negedge CLK);
        chk("sb_empty", sb.size(), 0);
        chk("done_count", done_cnt, done_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
